etpu_seq: RTL and testbench
===========================

Name: etpu_seq

Overview:
Job sequencer for the edu_tpu systolic array, on the Caravel wishbone bus as a register-mapped slave. On a start command it:
- loads N weight rows from the weight buffer into the array;
- streams M activation rows from the activation buffer;
- writes each result row to the result buffer at a fixed array latency;
- raises done/irq.
It owns all buffer addressing and array load/valid strobes. The array datapath itself is outside this block.

Parameters:
N, 3, array dimension (weight rows loaded per job), 2..8
LAT, 5, cycles from arr_a_valid of a row to that row's result at the array output (2N-1)
BASE_ADDR, 32'h3000_0000, wishbone base; block decodes adr[31:8]

Ports:
wb_clk_i  in  1  system clock
wb_rst_ni  in  1  synchronous active-low reset
wbs_stb_i  in  1  wishbone strobe
wbs_cyc_i  in  1  wishbone cycle
wbs_we_i  in  1  write enable
wbs_sel_i  in  4  byte select (ignored; full-word access only)
wbs_dat_i  in  32  write data
wbs_adr_i  in  32  address
wbs_ack_o  out  1  ack
wbs_dat_o  out  32  read data
wbuf_rd_en  out  1  weight buffer read strobe (data valid next cycle)
wbuf_rd_addr  out  $clog2(N)  weight row index
abuf_rd_en  out  1  activation buffer read strobe (data valid next cycle)
abuf_rd_addr  out  8  activation row index
arr_w_load  out  1  array captures weight row (wbuf_rd_en delayed 1)
arr_a_valid  out  1  array accepts activation row (abuf_rd_en delayed 1)
rbuf_wr_en  out  1  result buffer write strobe
rbuf_wr_addr  out  8  result row index
irq_o  out  1  level interrupt = done & irq_en

Behaviour:
- Reset: all outputs 0, state IDLE, all registers 0 (done, irq_en, rows, cycles).
- Wishbone, decode hit = stb & cyc & adr[31:8]==BASE_ADDR[31:8]:
  - ack is a one-cycle pulse, the cycle after a hit with ack low, so there is no back-to-back ack.
  - A miss never acks.
  - dat_o is valid with ack and is 0 otherwise.
- Register map (offset = adr[7:0]):
  - 0x00 CTRL (write only; reads 0): bit0 start, bit1 clear_done, bit2 abort, bit3 irq_en (sticky).
  - 0x04 STATUS (read only): bit0 busy, bit1 done, bits[6:4] state code, bit8 irq_en.
  - 0x08 ROWS (r/w): [7:0] = M.
  - 0x0C CYCLES (read only): count of busy cycles in the last or current job.
  - Other offsets: ack; reads 0; writes dropped.
- Writes to ROWS while busy are ignored. Start while busy is ignored.
- FSM states: IDLE(0), LOAD_W(1), STREAM(2), DRAIN(3).
- Start at write-accept cycle c:
  - done and CYCLES are cleared.
  - c+1..c+N: LOAD_W; wbuf_rd_en=1, addr 0..N-1.
  - c+N+1..c+N+M: STREAM; abuf_rd_en=1, addr 0..M-1.
  - Then DRAIN until the last result write.
  - Result row k: rbuf_wr_en at c+N+2+k+LAT, rbuf_wr_addr = k.
  - Implemented as a LAT+1 stage valid delay line plus a write counter.
  - The cycle after the last write: done=1, state IDLE.
- M=0: start goes straight to done=1 at c+1. No buffer reads, no writes.
- clear_done clears done. clear_done and start in the same write: start wins and done ends 0.
- abort from any non-IDLE state:
  - next cycle IDLE;
  - delay line flushed, so no further rbuf writes;
  - done stays 0.
- CYCLES increments every cycle state != IDLE and saturates at 32'hFFFF_FFFF.
- Reset mid-job: identical to power-on reset, with no trailing strobes.

Decomposition:
- etpu_pkg holds: register offsets, CTRL/STATUS bit positions, state enum (3-bit), address widths.
- One sub-module, etpu_valid_delay (parameter DEPTH, 1-bit shift register with synchronous flush), implements the LAT+1 result-valid pipeline.

Test Plan:
- Reset, then read STATUS and CYCLES -> both 0. irq_o=0. No buffer strobes for 20 cycles.
- ROWS=4, start at cycle c (N=3, LAT=5):
  - wbuf addr 0,1,2 at c+1..c+3;
  - abuf addr 0..3 at c+4..c+7;
  - rbuf writes addr 0..3 at c+10..c+13;
  - STATUS done=1 at c+14;
  - CYCLES=13.
- irq_en=1, job with ROWS=1 -> irq_o rises with done. clear_done -> irq_o=0 the next cycle.
- Start with ROWS=4, abort at c+6 -> rbuf_wr_en never asserts, busy=0 at c+7, done=0.
- Write ROWS=9 and a second start while busy -> ROWS reads 4 and the job completes unchanged. ROWS=0 start -> done next cycle with no reads.
- Access with adr=0x3000_0100 -> no ack. Access to offset 0x20 -> ack, read 0. wb_rst_ni low mid-STREAM -> all strobes 0 the next cycle.

Source files
------------

// File: rtl/etpu_pkg.sv
// Shared register map, bit positions and state encoding for the edu_tpu job sequencer.
package etpu_pkg;

  localparam logic [7:0] OFF_CTRL   = 8'h00;
  localparam logic [7:0] OFF_STATUS = 8'h04;
  localparam logic [7:0] OFF_ROWS   = 8'h08;
  localparam logic [7:0] OFF_CYCLES = 8'h0C;

  localparam int CTRL_START    = 0;
  localparam int CTRL_CLR_DONE = 1;
  localparam int CTRL_ABORT    = 2;
  localparam int CTRL_IRQ_EN   = 3;

  localparam int STAT_BUSY      = 0;
  localparam int STAT_DONE      = 1;
  localparam int STAT_STATE_LSB = 4;
  localparam int STAT_IRQ_EN    = 8;

  localparam int ROW_AW = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_W = 3'd1,
    ST_STREAM = 3'd2,
    ST_DRAIN  = 3'd3
  } state_e;

endpackage

// File: rtl/etpu_valid_delay.sv
// Fixed-depth 1-bit valid pipeline; flush drops everything in flight, including this cycle's input.
module etpu_valid_delay #(
  parameter int DEPTH = 6
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic flush_i,
  input  logic in_i,
  output logic out_o
);

  logic [DEPTH-1:0] sr_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) sr_q <= '0;
    else                    sr_q <= {sr_q[DEPTH-2:0], in_i};
  end

  assign out_o = sr_q[DEPTH-1];

endmodule

// File: rtl/etpu_seq.sv
// Wishbone-mapped job sequencer: weight load, activation stream, result write-back.
//   state     | meaning
//   IDLE      | no job; waiting for start
//   LOAD_W    | reading weight rows 0..N-1
//   STREAM    | reading activation rows 0..M-1
//   DRAIN     | waiting for the last result row write
module etpu_seq
  import etpu_pkg::*;
#(
  parameter int          N         = 3,
  parameter int          LAT       = 5,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_ni,
  input  logic                 wbs_stb_i,
  input  logic                 wbs_cyc_i,
  input  logic                 wbs_we_i,
  input  logic [3:0]           wbs_sel_i,
  input  logic [31:0]          wbs_dat_i,
  input  logic [31:0]          wbs_adr_i,
  output logic                 wbs_ack_o,
  output logic [31:0]          wbs_dat_o,
  output logic                 wbuf_rd_en,
  output logic [$clog2(N)-1:0] wbuf_rd_addr,
  output logic                 abuf_rd_en,
  output logic [ROW_AW-1:0]    abuf_rd_addr,
  output logic                 arr_w_load,
  output logic                 arr_a_valid,
  output logic                 rbuf_wr_en,
  output logic [ROW_AW-1:0]    rbuf_wr_addr,
  output logic                 irq_o
);

  localparam int WAW = $clog2(N);

  state_e            state_q, state_d;
  logic [ROW_AW-1:0] cnt_q, cnt_d, wr_cnt_q, wr_cnt_d, rows_q;
  logic [31:0]       cycles_q, cycles_d, dat_q, rdata;
  logic              done_q, done_d, irq_en_q, ack_q, w_load_q, a_valid_q;
  logic              hit, acc, wr_acc, rd_acc, ctrl_wr, busy;
  logic              start_go, abort_go, clr_go, rvalid, last_wr;
  logic              unused_bits;

  // A hit is accepted only while ack is low, which spaces acks at least one cycle apart.
  assign hit      = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign acc      = hit & ~ack_q;
  assign wr_acc   = acc & wbs_we_i;
  assign rd_acc   = acc & ~wbs_we_i;
  assign ctrl_wr  = wr_acc & (wbs_adr_i[7:0] == OFF_CTRL);
  assign busy     = (state_q != ST_IDLE);
  assign start_go = ctrl_wr & wbs_dat_i[CTRL_START] & ~busy;
  assign abort_go = ctrl_wr & wbs_dat_i[CTRL_ABORT] & busy;
  assign clr_go   = ctrl_wr & wbs_dat_i[CTRL_CLR_DONE];
  assign last_wr  = rvalid & (wr_cnt_q == rows_q - 8'd1);
  assign unused_bits = ^{wbs_sel_i, wbs_dat_i[31:8]};

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      wr_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wr_cnt_d = rvalid ? wr_cnt_q + 8'd1 : wr_cnt_q;
    case (state_q)
      ST_IDLE: if (start_go) begin
        cnt_d    = '0;
        wr_cnt_d = '0;
        if (rows_q != '0) state_d = ST_LOAD_W;
      end
      ST_LOAD_W: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == 8'(N - 1)) begin
          cnt_d   = '0;
          state_d = ST_STREAM;
        end
      end
      ST_STREAM: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == rows_q - 8'd1) begin
          cnt_d   = '0;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: ;
      default: state_d = ST_IDLE;
    endcase
    if ((busy && last_wr) || abort_go) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end
  end

  always_comb begin
    wbuf_rd_en   = (state_q == ST_LOAD_W);
    abuf_rd_en   = (state_q == ST_STREAM);
    wbuf_rd_addr = wbuf_rd_en ? cnt_q[WAW-1:0] : '0;
    abuf_rd_addr = abuf_rd_en ? cnt_q : '0;
    rbuf_wr_en   = rvalid;
    rbuf_wr_addr = rvalid ? wr_cnt_q : '0;
  end

  etpu_valid_delay #(.DEPTH(LAT + 1)) u_valid_delay (
    .clk_i   (wb_clk_i),
    .rst_ni  (wb_rst_ni),
    .flush_i (abort_go),
    .in_i    (abuf_rd_en),
    .out_o   (rvalid)
  );

  always_comb begin
    done_d = done_q;
    if (clr_go)           done_d = 1'b0;
    if (busy && last_wr)  done_d = 1'b1;
    if (start_go)         done_d = (rows_q == '0);
    cycles_d = cycles_q;
    if (start_go)                        cycles_d = '0;
    else if (busy && cycles_q != '1)     cycles_d = cycles_q + 32'd1;
  end

  always_comb begin
    rdata = '0;
    case (wbs_adr_i[7:0])
      OFF_STATUS: begin
        rdata[STAT_BUSY]              = busy;
        rdata[STAT_DONE]              = done_q;
        rdata[STAT_STATE_LSB +: 3]    = state_q;
        rdata[STAT_IRQ_EN]            = irq_en_q;
      end
      OFF_ROWS:   rdata[7:0] = rows_q;
      OFF_CYCLES: rdata      = cycles_q;
      default:    ;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      ack_q     <= 1'b0;
      dat_q     <= '0;
      irq_en_q  <= 1'b0;
      rows_q    <= '0;
      done_q    <= 1'b0;
      cycles_q  <= '0;
      w_load_q  <= 1'b0;
      a_valid_q <= 1'b0;
    end else begin
      ack_q     <= acc;
      dat_q     <= rd_acc ? rdata : '0;
      if (ctrl_wr) irq_en_q <= wbs_dat_i[CTRL_IRQ_EN];
      if (wr_acc && wbs_adr_i[7:0] == OFF_ROWS && !busy) rows_q <= wbs_dat_i[7:0];
      done_q    <= done_d;
      cycles_q  <= cycles_d;
      w_load_q  <= wbuf_rd_en;
      a_valid_q <= abuf_rd_en;
    end
  end

  assign wbs_ack_o   = ack_q;
  assign wbs_dat_o   = dat_q;
  assign arr_w_load  = w_load_q;
  assign arr_a_valid = a_valid_q;
  assign irq_o       = done_q & irq_en_q;

endmodule

// File: tb/tb_etpu_seq.sv
// Directed bench for etpu_seq (N=3, LAT=5); t counts cycles from the start-write accept cycle.
module tb_etpu_seq;

  localparam logic [31:0] BASE   = 32'h3000_0000;
  localparam logic [31:0] A_CTRL = BASE + 32'h00;
  localparam logic [31:0] A_STAT = BASE + 32'h04;
  localparam logic [31:0] A_ROWS = BASE + 32'h08;
  localparam logic [31:0] A_CYC  = BASE + 32'h0C;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [31:0] wdat = '0, adr = '0;
  logic        ack;
  logic [31:0] rdat_o;
  logic        wbuf_rd_en, abuf_rd_en, arr_w_load, arr_a_valid, rbuf_wr_en, irq_o;
  logic [1:0]  wbuf_rd_addr;
  logic [7:0]  abuf_rd_addr, rbuf_wr_addr;

  int checks = 0;
  int failures = 0;
  int n_wbuf = 0, n_abuf = 0, n_rbuf = 0;
  int s_wbuf, s_abuf, s_rbuf;

  etpu_seq #(.N(3), .LAT(5), .BASE_ADDR(BASE)) dut (
    .wb_clk_i     (clk),
    .wb_rst_ni    (rst_n),
    .wbs_stb_i    (stb),
    .wbs_cyc_i    (cyc),
    .wbs_we_i     (we),
    .wbs_sel_i    (4'hF),
    .wbs_dat_i    (wdat),
    .wbs_adr_i    (adr),
    .wbs_ack_o    (ack),
    .wbs_dat_o    (rdat_o),
    .wbuf_rd_en   (wbuf_rd_en),
    .wbuf_rd_addr (wbuf_rd_addr),
    .abuf_rd_en   (abuf_rd_en),
    .abuf_rd_addr (abuf_rd_addr),
    .arr_w_load   (arr_w_load),
    .arr_a_valid  (arr_a_valid),
    .rbuf_wr_en   (rbuf_wr_en),
    .rbuf_wr_addr (rbuf_wr_addr),
    .irq_o        (irq_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (wbuf_rd_en) n_wbuf++;
    if (abuf_rd_en) n_abuf++;
    if (rbuf_wr_en) n_rbuf++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] strobes();
    return {9'b0, wbuf_rd_en, wbuf_rd_addr, abuf_rd_en, abuf_rd_addr,
            rbuf_wr_en, rbuf_wr_addr, arr_w_load, arr_a_valid};
  endfunction

  function automatic logic [31:0] exp_strb(bit w_en, int w_a, bit a_en, int a_a,
                                           bit r_en, int r_a, bit wl, bit av);
    logic [1:0] wa = w_en ? 2'(w_a) : 2'd0;
    logic [7:0] aa = a_en ? 8'(a_a) : 8'd0;
    logic [7:0] ra = r_en ? 8'(r_a) : 8'd0;
    return {9'b0, w_en, wa, a_en, aa, r_en, ra, wl, av};
  endfunction

  // Called at a negedge; returns at the negedge of the ack cycle (or after the bound).
  task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                         output logic [31:0] rd, output logic acked);
    stb = 1'b1; cyc = 1'b1; we = w; adr = a; wdat = d;
    acked = 1'b0; rd = '0;
    for (int i = 0; i < 8 && !acked; i++) begin
      @(negedge clk);
      if (ack) begin
        acked = 1'b1;
        rd = rdat_o;
      end
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
  endtask

  task automatic wb_wr(input string tag, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] rd;
    logic acked;
    wb_xfer(1'b1, a, d, rd, acked);
    check({tag, "_ack"}, {31'b0, acked}, 32'd1);
  endtask

  task automatic wb_rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] rd;
    logic acked;
    wb_xfer(1'b0, a, '0, rd, acked);
    check({tag, "_ack"}, {31'b0, acked}, 32'd1);
    check(tag, rd, exp);
  endtask

  task automatic snap();
    s_wbuf = n_wbuf; s_abuf = n_abuf; s_rbuf = n_rbuf;
  endtask

  initial begin
    logic [31:0] rd;
    logic acked;

    // reset and idle
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("rst_strobes", strobes(), 32'd0);
    check("rst_irq", {31'b0, irq_o}, 32'd0);
    check("rst_ack_dat", {31'b0, ack} | rdat_o, 32'd0);
    wb_rd("rst_status", A_STAT, 32'h0);
    wb_rd("rst_cycles", A_CYC, 32'h0);
    snap();
    repeat (20) @(negedge clk);
    check("rst_no_strobes", n_wbuf + n_abuf + n_rbuf - s_wbuf - s_abuf - s_rbuf, 32'd0);

    // full job, M=4: per-cycle strobe timeline
    wb_wr("rows4", A_ROWS, 32'd4);
    wb_rd("rows4_rd", A_ROWS, 32'd4);
    wb_wr("start", A_CTRL, 32'h1);
    for (int t = 1; t <= 14; t++) begin
      if (t > 1) @(negedge clk);
      check($sformatf("job_t%0d", t), strobes(),
            exp_strb(t >= 1 && t <= 3, t - 1, t >= 4 && t <= 7, t - 4,
                     t >= 10 && t <= 13, t - 10, t >= 2 && t <= 4, t >= 5 && t <= 8));
    end
    wb_rd("job_status_done", A_STAT, 32'h2);
    wb_rd("job_cycles", A_CYC, 32'd13);

    // ROWS write and second start while busy are dropped
    snap();
    wb_wr("ovl_start", A_CTRL, 32'h1);
    wb_wr("ovl_rows9", A_ROWS, 32'd9);
    wb_wr("ovl_start2", A_CTRL, 32'h1);
    wb_rd("ovl_rows_rd", A_ROWS, 32'd4);
    repeat (20) @(negedge clk);
    check("ovl_wbuf_n", n_wbuf - s_wbuf, 32'd3);
    check("ovl_abuf_n", n_abuf - s_abuf, 32'd4);
    check("ovl_rbuf_n", n_rbuf - s_rbuf, 32'd4);
    wb_rd("ovl_cycles", A_CYC, 32'd13);

    // irq follows done when enabled; clear_done drops it next cycle
    wb_wr("irq_en_clr", A_CTRL, 32'h0A);
    check("irq_after_clr", {31'b0, irq_o}, 32'd0);
    wb_wr("irq_rows1", A_ROWS, 32'd1);
    wb_wr("irq_start", A_CTRL, 32'h09);
    for (int t = 1; t <= 11; t++) begin
      if (t > 1) @(negedge clk);
      check($sformatf("irq_t%0d", t), {31'b0, irq_o}, (t == 11) ? 32'd1 : 32'd0);
    end
    wb_wr("irq_clear", A_CTRL, 32'h0A);
    check("irq_cleared", {31'b0, irq_o}, 32'd0);
    wb_rd("irq_status", A_STAT, 32'h100);

    // abort at t=6
    wb_wr("ab_rows4", A_ROWS, 32'd4);
    snap();
    wb_wr("ab_start", A_CTRL, 32'h09);
    repeat (5) @(negedge clk);
    wb_wr("ab_abort", A_CTRL, 32'h0C);
    wb_rd("ab_status", A_STAT, 32'h100);
    repeat (20) @(negedge clk);
    check("ab_no_rbuf", n_rbuf - s_rbuf, 32'd0);
    check("ab_irq", {31'b0, irq_o}, 32'd0);
    wb_rd("ab_cycles", A_CYC, 32'd6);

    // M=0: immediate done, no buffer traffic
    wb_wr("m0_rows", A_ROWS, 32'd0);
    snap();
    wb_wr("m0_start", A_CTRL, 32'h09);
    check("m0_irq", {31'b0, irq_o}, 32'd1);
    wb_rd("m0_status", A_STAT, 32'h102);
    repeat (10) @(negedge clk);
    check("m0_no_strobes", n_wbuf + n_abuf + n_rbuf - s_wbuf - s_abuf - s_rbuf, 32'd0);
    wb_rd("m0_cycles", A_CYC, 32'd0);

    // address decode
    wb_xfer(1'b0, 32'h3000_0100, '0, rd, acked);
    check("miss_noack", {31'b0, acked}, 32'd0);
    wb_rd("unmapped_rd", BASE + 32'h20, 32'd0);
    wb_wr("unmapped_wr", BASE + 32'h20, 32'hFF);
    wb_rd("rows_kept", A_ROWS, 32'd0);
    wb_rd("ctrl_rd0", A_CTRL, 32'd0);
    check("dat_idle0", rdat_o, 32'd0);

    // reset mid-STREAM
    wb_wr("rs_rows4", A_ROWS, 32'd4);
    wb_wr("rs_start", A_CTRL, 32'h1);
    repeat (4) @(negedge clk);
    check("rs_in_stream", {31'b0, abuf_rd_en}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("rs_strobes0", strobes(), 32'd0);
    check("rs_irq0", {31'b0, irq_o}, 32'd0);
    snap();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("rs_no_trailing", n_wbuf + n_abuf + n_rbuf - s_wbuf - s_abuf - s_rbuf, 32'd0);
    wb_rd("rs_status", A_STAT, 32'h0);
    wb_rd("rs_rows", A_ROWS, 32'h0);
    wb_rd("rs_cycles", A_CYC, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
